// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port RAM arbiter: state encoding,
// byte-enable codes and the byte merge/extract functions.
package mem_arb_pkg;

  localparam int WORD_W     = 16;
  localparam int REQ_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MRG,
    WR,
    RESP
  } state_t;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  // Replace the enabled lane(s) of the stored word with the matching write lane(s).
  function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] old_word,
                                                   input logic [WORD_W-1:0] wdata,
                                                   input logic [1:0]        be);
    logic [WORD_W-1:0] merged;
    merged = old_word;
    if (be[0]) merged[7:0]  = wdata[7:0];
    if (be[1]) merged[15:8] = wdata[15:8];
    return merged;
  endfunction

  // Right-justify the selected byte; a no-op read returns zero.
  function automatic logic [WORD_W-1:0] byte_extract(input logic [WORD_W-1:0] word,
                                                     input logic [1:0]        be);
    logic [WORD_W-1:0] result;
    case (be)
      BE_WORD: result = word;
      BE_LO:   result = {8'h00, word[7:0]};
      BE_HI:   result = {8'h00, word[15:8]};
      default: result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bus interfaces for the arbiter: one requester port (req/ack handshake)
// and the single-port RAM bus. master = driving side, slave = responding side.
interface mem_port_if #(
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [1:0]        be;
  logic [15:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ack, rdata
  );
endinterface

interface ram_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       addr;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        be;
  logic              we;
  logic [DATA_W-1:0] data_out;

  modport master (
    output addr, data_in, be, we,
    input  data_out
  );

  modport slave (
    input  addr, data_in, be, we,
    output data_out
  );
endinterface

// File: rtl/mem_arb_grant.sv
// Two-way grant: fixed M1 priority by default; with MEM_ARB_ROUND_ROBIN_EN
// defined, conflicts go to the port not granted last (pointer resets to M1).
module mem_arb_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic reset,
  input  logic take,
`endif
  input  logic req0,
  input  logic req1,
  output logic gnt_any,
  output logic gnt_port
);

  assign gnt_any = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (take) begin
      last_q <= gnt_port;
    end
  end

  always_comb begin
    if (req0 && req1) begin
      gnt_port = ~last_q;
    end else begin
      gnt_port = req1;
    end
  end
`else
  assign gnt_port = req1;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one 16-bit word RAM between M0 and M1; byte writes
// become read-modify-write. MEM_ARB_ROUND_ROBIN_EN selects round-robin grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = WORD_W
) (
  input  logic      clk,
  input  logic      reset,
  mem_port_if.slave m0,
  mem_port_if.slave m1,
  ram_if.master     ram,
  output logic      busy
);

  state_t              state_q, state_d;
  logic                gnt_any, gnt_port;

  logic                sel_we;
  logic [1:0]          sel_be;
  logic [REQ_ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  logic                port_q;
  logic                we_q;
  logic [1:0]          be_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  logic                partial_wr;
  logic                resp_rd;
  logic [DATA_W-1:0]   rd_word;
  logic                unused_addr_hi;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic take;
  assign take = (state_q == IDLE) && gnt_any;
`endif

  mem_arb_grant u_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk      (clk),
    .reset    (reset),
    .take     (take),
`endif
    .req0     (m0.req),
    .req1     (m1.req),
    .gnt_any  (gnt_any),
    .gnt_port (gnt_port)
  );

  assign sel_we    = gnt_port ? m1.we    : m0.we;
  assign sel_be    = gnt_port ? m1.be    : m0.be;
  assign sel_addr  = gnt_port ? m1.addr  : m0.addr;
  assign sel_wdata = gnt_port ? m1.wdata : m0.wdata;

  // Address bits above ADDR_W wrap away.
  assign unused_addr_hi = ^sel_addr[REQ_ADDR_W-1:ADDR_W];

  assign partial_wr = we_q && (be_q != BE_WORD) && (be_q != BE_NONE);
  assign resp_rd    = (state_q == RESP) && !we_q;
  assign rd_word    = byte_extract(ram.data_out, be_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and a latch is never inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          if (sel_be == BE_NONE) begin
            state_d = RESP;
          end else if (sel_we && (sel_be == BE_WORD)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:      state_d = partial_wr ? MRG : RESP;
      MRG:     state_d = RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured once at grant; the requester may drop req afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= BE_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state_q == IDLE) && gnt_any) begin
      port_q  <= gnt_port;
      we_q    <= sel_we;
      be_q    <= sel_be;
      addr_q  <= sel_addr[ADDR_W-1:0];
      wdata_q <= sel_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (resp_rd) begin
      if (port_q) begin
        rdata1_q <= rd_word;
      end else begin
        rdata0_q <= rd_word;
      end
    end
  end

  // RAM strobes decode from the state register alone, so reset kills ram.we at once.
  always_comb begin
    ram.addr    = {{(REQ_ADDR_W - ADDR_W){1'b0}}, addr_q};
    ram.be      = BE_WORD;
    ram.we      = (state_q == MRG) || (state_q == WR);
    ram.data_in = wdata_q;
    if (state_q == MRG) begin
      ram.data_in = byte_merge(ram.data_out, wdata_q, be_q);
    end
  end

  // The RAM word arrives during RESP, so the ack cycle forwards it; the register holds it after.
  always_comb begin
    m0.ack   = (state_q == RESP) && !port_q;
    m1.ack   = (state_q == RESP) &&  port_q;
    m0.rdata = (resp_rd && !port_q) ? rd_word : rdata0_q;
    m1.rdata = (resp_rd &&  port_q) ? rd_word : rdata1_q;
  end

  assign busy = (state_q != IDLE);

endmodule
